// File: rtl/fifo_control.sv
// Control half of a synchronous FIFO: pointers, occupancy, status flags and
// memory strobes. The storage array lives outside and has a one-cycle read latency.
module fifo_control #(
  parameter int MEM_LENGHT      = 8,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  output logic       write_enable,
  output logic       read_enable,
  output logic [3:0] write_addr,
  output logic [3:0] read_addr,
  output logic       data_valid,
  output logic [4:0] count,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       almost_full,
  output logic       almost_empty,
  output logic       overflow,
  output logic       underflow
);

  localparam int AW = (MEM_LENGHT > 1) ? $clog2(MEM_LENGHT) : 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Flags come straight from the registered occupancy, so they never glitch
  // on same-cycle requests.
  assign fifo_empty   = (count == 5'd0);
  assign fifo_full    = (count == 5'(MEM_LENGHT));
  assign almost_full  = (count >= 5'(ALMOST_FULL_TH));
  assign almost_empty = (count <= 5'(ALMOST_EMPTY_TH));

  // A pop frees a slot in the same cycle, which is what lets a push through
  // on a full FIFO; a pop on empty is refused even if a push arrives with it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    if (!reset) begin
      pop_ok  = pop && !fifo_empty;
      push_ok = push && (!fifo_full || pop_ok);
    end
  end

  assign write_enable = push_ok;
  assign read_enable  = pop_ok;
  assign write_addr   = 4'(wr_ptr);
  assign read_addr    = 4'(rd_ptr);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= 5'd0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      // Power-of-two depth: pointers wrap naturally at their own width.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase

      // Memory answers one cycle after the read strobe.
      data_valid <= pop_ok;

      if (push && !push_ok) overflow  <= 1'b1;
      if (pop && !pop_ok)   underflow <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_control.md
FIFO_CONTROL -- requirements
Module: fifo_control

Interface
REQ-001 SHALL have parameter MEM_LENGHT, default 8, number of memory entries (power of two, 2..16).
REQ-002 SHALL have parameter ALMOST_FULL_TH, default 6, occupancy at or above which almost_full asserts.
REQ-003 SHALL have parameter ALMOST_EMPTY_TH, default 2, occupancy at or below which almost_empty asserts.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port push  input  1  request to write one word into the FIFO memory this cycle.
REQ-007 SHALL have port pop  input  1  request to read one word from the FIFO memory this cycle.
REQ-008 SHALL have port write_enable  output  1  write strobe to memory.
REQ-009 SHALL have port read_enable  output  1  read strobe to memory.
REQ-010 SHALL have port write_addr  output  4  memory write address (write pointer).
REQ-011 SHALL have port read_addr  output  4  memory read address (read pointer).
REQ-012 SHALL have port data_valid  output  1  memory read data (fifo_Data_out) valid this cycle.
REQ-013 SHALL have port count  output  5  current occupancy, 0..MEM_LENGHT.
REQ-014 SHALL have ports fifo_full, fifo_empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL hold wr_ptr and rd_ptr registers of log2(MEM_LENGHT) bits, zero-extended onto write_addr/read_addr; both wrap from MEM_LENGHT-1 to 0.
REQ-017 SHALL accept a push when push=1 and (fifo_full=0 or an accepted pop occurs in the same cycle).
REQ-018 SHALL accept a pop when pop=1 and fifo_empty=0; pop on empty is never accepted, even with a simultaneous push.
REQ-019 SHALL drive write_enable combinationally = accepted push and read_enable combinationally = accepted pop, in the same cycle as the request, with write_addr=wr_ptr and read_addr=rd_ptr.
REQ-020 SHALL increment wr_ptr on each accepted push and rd_ptr on each accepted pop, at the same clock edge the memory samples the strobe.
REQ-021 SHALL update count: +1 push only, -1 pop only, unchanged for both or neither; count never leaves 0..MEM_LENGHT.
REQ-022 SHALL derive fifo_empty=(count==0), fifo_full=(count==MEM_LENGHT), almost_full=(count>=ALMOST_FULL_TH), almost_empty=(count<=ALMOST_EMPTY_TH) from the registered count.
REQ-023 SHALL register data_valid as read_enable delayed one cycle, aligned with the memory's one-cycle read latency.
REQ-024 SHALL set overflow when push=1 is rejected and underflow when pop=1 is rejected; both remain 1 until reset.
REQ-025 SHALL keep pointers, count and data_valid unchanged for rejected requests.
REQ-026 SHALL, when full with push and pop together, accept both; the memory returns the old word at rd_ptr while the new word overwrites that slot.

Reset
REQ-027 SHALL, when reset=1 at a posedge, clear wr_ptr, rd_ptr, count, data_valid, overflow and underflow to 0, giving fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
REQ-028 SHALL give reset priority over push/pop in the same cycle; write_enable and read_enable are 0 while reset=1.
REQ-029 SHALL discard all stored contents on reset mid-operation (occupancy 0); the memory array itself is not cleared.

Verification
REQ-030 SHALL cover: reset, then 8 pushes -> write_addr 0..7, count 8, fifo_full=1, almost_full=1 from count 6, overflow=0.
REQ-031 SHALL cover: full FIFO, push only -> write_enable=0, wr_ptr unchanged, overflow=1 and still 1 ten cycles later.
REQ-032 SHALL cover: 8 pops after fill -> read_addr 0..7, data_valid one cycle after each read_enable, fifo_empty=1 after last pop, pop once more -> underflow=1.
REQ-033 SHALL cover: 12 pushes interleaved with 12 pops -> both pointers wrap 7->0, count never exceeds 8, no error flags.
REQ-034 SHALL cover: empty, push+pop together -> push accepted, pop rejected, count 1, underflow=1; full, push+pop -> both accepted, count stays 8.
REQ-035 SHALL cover: reset asserted at count 5 with push=1 -> next cycle count 0, pointers 0, fifo_empty=1, errors 0, write_enable=0 during reset.
